// File: rtl/afe_chan_sampler.sv
// AFE comparator-pair sampler: 2-flop sync, hysteresis resolve, decimation,
// and an edge-trigger FSM on one selected channel.
module afe_chan_sampler #(
   parameter int NUM_CH  = 5,
   parameter int DECIM_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_CH-1:0]  chL,
   input  logic [NUM_CH-1:0]  chH,
   input  logic [DECIM_W-1:0] decim,
   input  logic               arm,
   input  logic               disarm,
   input  logic [2:0]         trig_ch,
   input  logic               trig_pol,
   output logic [NUM_CH-1:0]  smpl,
   output logic               smpl_vld,
   output logic               trig,
   output logic               trigd,
   output logic               armed
);

   typedef enum logic [1:0] {IDLE, ARMED, WAIT_EDGE, TRIGGERED} state_t;

   state_t state, state_n;
   logic [NUM_CH-1:0]  l_s1, l_s2, h_s1, h_s2;
   logic [NUM_CH-1:0]  lvl;
   logic [DECIM_W-1:0] dec_cnt;
   logic [NUM_CH-1:0]  smpl_sh;
   logic               ch_ok, b, trig_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         l_s1 <= '0;
         l_s2 <= '0;
         h_s1 <= '0;
         h_s2 <= '0;
      end else begin
         l_s1 <= chL;
         l_s2 <= l_s1;
         h_s1 <= chH;
         h_s2 <= h_s1;
      end
   end

   // H wins outright; between thresholds (L=1,H=0) the previous level holds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) lvl <= '0;
      else     lvl <= h_s2 | (l_s2 & lvl);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dec_cnt  <= '0;
         smpl     <= '0;
         smpl_vld <= 1'b0;
      end else if (dec_cnt >= decim) begin
         dec_cnt  <= '0;
         smpl     <= lvl;
         smpl_vld <= 1'b1;
      end else begin
         dec_cnt  <= dec_cnt + 1'b1;
         smpl_vld <= 1'b0;
      end
   end

   assign ch_ok   = (int'(trig_ch) < NUM_CH);
   assign smpl_sh = smpl >> trig_ch;
   assign b       = smpl_sh[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         trig  <= 1'b0;
         trigd <= 1'b0;
         armed <= 1'b0;
      end else begin
         state <= state_n;
         trig  <= trig_n;
         trigd <= (state_n == TRIGGERED);
         armed <= (state_n == ARMED) || (state_n == WAIT_EDGE);
      end
   end

   always_comb begin
      state_n = state;
      trig_n  = 1'b0;
      if (disarm) begin
         state_n = IDLE;
      end else begin
         case (state)
            IDLE:      if (arm) state_n = ARMED;
            ARMED:     if (smpl_vld && ch_ok && (b == ~trig_pol)) state_n = WAIT_EDGE;
            WAIT_EDGE: if (smpl_vld && ch_ok && (b == trig_pol)) begin
                          state_n = TRIGGERED;
                          trig_n  = 1'b1;
                       end
            TRIGGERED: if (arm) state_n = ARMED;
            default:   state_n = IDLE;
         endcase
      end
   end

endmodule
